// File: rtl/bank_group_scheduler.sv
// Bank-group command scheduler.
// Grants one of four bank groups at a time, round-robin from the group after
// the last grant, and enforces tCCD_S / tCCD_L / read-write turnaround idle
// gaps between a completion and the next start. A watchdog aborts a grant
// that never sees its done pulse.
module bank_group_scheduler #(
  parameter int TCCD_S  = 1,
  parameter int TCCD_L  = 3,
  parameter int T_RW    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] rd_wr,
  input  logic [3:0] done,
  output logic [3:0] start,
  output logic [1:0] sel,
  output logic       wr_en,
  output logic       busy,
  output logic       err_timeout
);

  localparam int ACW = $clog2(TIMEOUT + 1);
  localparam logic [ACW-1:0] ACT_LAST = ACW'(TIMEOUT - 1);
  localparam logic [4:0] TS_GAP  = 5'(TCCD_S);
  localparam logic [4:0] TL_GAP  = 5'(TCCD_L);
  localparam logic [4:0] TRW_GAP = 5'(T_RW);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GAP = 2'd1,
    S_ACTIVE   = 2'd2
  } state_t;

  state_t         state_r;
  logic [1:0]     rr_ptr_r;
  logic [1:0]     win_r;        // latched winner (WAIT_GAP) or granted group (ACTIVE)
  logic [1:0]     last_grp_r;
  logic           last_dir_r;
  logic           hist_vld_r;   // no grant since reset -> gap is zero
  logic [3:0]     gap_cnt_r;    // idle cycles since the last done/timeout
  logic [ACW-1:0] act_cnt_r;

  logic [7:0]     rot_wide_s;
  logic [3:0]     rot_s;
  logic [1:0]     arb_off_s;
  logic [1:0]     arb_win_s;
  logic           arb_hit_s;
  logic [4:0]     arb_gap_s;
  logic [4:0]     wait_gap_s;
  logic [4:0]     elapsed_s;
  logic           done_hit_s;
  logic           timeout_s;
  logic           grant_s;
  logic [1:0]     grant_grp_s;
  logic [3:0]     gap_inc_s;

  // Required idle gap before granting grp with direction dir, given history.
  function automatic logic [4:0] calc_gap(
    input logic [1:0] grp,
    input logic       dir,
    input logic       vld,
    input logic [1:0] lgrp,
    input logic       ldir
  );
    logic [4:0] g;
    if (!vld) begin
      g = 5'd0;
    end else begin
      if (grp == lgrp) begin
        g = TL_GAP;
      end else begin
        g = TS_GAP;
      end
      if (dir != ldir) begin
        g = g + TRW_GAP;
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin arbitration: first requesting group at or above rr_ptr, wrapping.
  always_comb begin
    rot_wide_s = {req, req} >> rr_ptr_r;
    rot_s      = rot_wide_s[3:0];
    casez (rot_s)
      4'b???1: arb_off_s = 2'd0;
      4'b??10: arb_off_s = 2'd1;
      4'b?100: arb_off_s = 2'd2;
      4'b1000: arb_off_s = 2'd3;
      default: arb_off_s = 2'd0;
    endcase
    arb_hit_s = |req;
    arb_win_s = rr_ptr_r + arb_off_s;
  end

  // Gap bookkeeping and grant decision for the current state.
  always_comb begin
    arb_gap_s  = calc_gap(arb_win_s, rd_wr[arb_win_s], hist_vld_r, last_grp_r, last_dir_r);
    wait_gap_s = calc_gap(win_r, rd_wr[win_r], hist_vld_r, last_grp_r, last_dir_r);
    // Counting the current idle cycle, this many idle cycles will have elapsed.
    elapsed_s  = {1'b0, gap_cnt_r} + 5'd1;
    done_hit_s = done[win_r];
    timeout_s  = (!done_hit_s) && (act_cnt_r == ACT_LAST);
    if (gap_cnt_r == 4'd15) begin
      gap_inc_s = 4'd15;
    end else begin
      gap_inc_s = gap_cnt_r + 4'd1;
    end
    grant_s     = 1'b0;
    grant_grp_s = arb_win_s;
    case (state_r)
      S_IDLE: begin
        grant_s     = arb_hit_s && (elapsed_s >= arb_gap_s);
        grant_grp_s = arb_win_s;
      end
      S_WAIT_GAP: begin
        grant_s     = req[win_r] && (elapsed_s >= wait_gap_s);
        grant_grp_s = win_r;
      end
      S_ACTIVE: begin
        // Only a zero-gap grant may follow a done back to back.
        grant_s     = done_hit_s && arb_hit_s && (arb_gap_s == 5'd0);
        grant_grp_s = arb_win_s;
      end
      default: begin
        grant_s     = 1'b0;
        grant_grp_s = arb_win_s;
      end
    endcase
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= 2'd0;
      win_r       <= 2'd0;
      last_grp_r  <= 2'd0;
      last_dir_r  <= 1'b0;
      hist_vld_r  <= 1'b0;
      gap_cnt_r   <= 4'd15;
      act_cnt_r   <= '0;
      start       <= 4'd0;
      sel         <= 2'd0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (grant_s) begin
        state_r    <= S_ACTIVE;
        win_r      <= grant_grp_s;
        rr_ptr_r   <= grant_grp_s + 2'd1;
        last_grp_r <= grant_grp_s;
        last_dir_r <= rd_wr[grant_grp_s];
        hist_vld_r <= 1'b1;
        gap_cnt_r  <= 4'd0;
        act_cnt_r  <= '0;
        start      <= onehot4(grant_grp_s);
        sel        <= grant_grp_s;
        wr_en      <= rd_wr[grant_grp_s];
        busy       <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            gap_cnt_r <= gap_inc_s;
            if (arb_hit_s) begin
              state_r <= S_WAIT_GAP;
              win_r   <= arb_win_s;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_WAIT_GAP: begin
            gap_cnt_r <= gap_inc_s;
            if (!req[win_r]) begin
              state_r <= S_IDLE;
            end else begin
              state_r <= S_WAIT_GAP;
            end
          end
          S_ACTIVE: begin
            if (done_hit_s || timeout_s) begin
              // A timeout is treated like a done for gap purposes.
              state_r     <= S_IDLE;
              gap_cnt_r   <= 4'd0;
              start       <= 4'd0;
              wr_en       <= 1'b0;
              busy        <= 1'b0;
              err_timeout <= timeout_s;
            end else begin
              act_cnt_r <= act_cnt_r + {{(ACW-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_r <= S_IDLE;
            start   <= 4'd0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bank_group_scheduler.sv
// Self-checking bench for bank_group_scheduler: expected grants are queued
// when stimulus is applied and popped as the scheduler issues starts.
module tb_bank_group_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, rd_wr, done;
  logic [3:0] start;
  logic [1:0] sel;
  logic       wr_en, busy, err_timeout;
  logic [3:0] req2, rd_wr2, done2;
  logic [3:0] start2;
  logic [1:0] sel2;
  logic       wr_en2, busy2, err_timeout2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] grp;
    logic       wr;
    int         gap;
    int         hold;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bank_group_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_wr(rd_wr), .done(done),
    .start(start), .sel(sel), .wr_en(wr_en), .busy(busy), .err_timeout(err_timeout)
  );

  bank_group_scheduler #(.TCCD_S(0), .TCCD_L(3), .T_RW(0), .TIMEOUT(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .rd_wr(rd_wr2), .done(done2),
    .start(start2), .sel(sel2), .wr_en(wr_en2), .busy(busy2), .err_timeout(err_timeout2)
  );

  function automatic logic [3:0] oh(input logic [1:0] g);
    logic [3:0] v;
    v = 4'd0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count idle cycles until a start appears (bounded).
  task automatic wait_start(input bit use2, output int cyc);
    cyc = 0;
    while ((((use2 != 1'b0) ? start2 : start) == 4'd0) && (cyc < 200)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'd0; rd_wr = 4'd0; done = 4'd0;
    req2 = 4'd0; rd_wr2 = 4'd0; done2 = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; req = 4'hF;
    tick();
    n_cmp++; if (start !== 4'd0) begin n_bad++; $display("FAIL reset_start: got %b expected 0000", start); end
    n_cmp++; if ({sel, wr_en, busy, err_timeout} !== 5'd0) begin n_bad++; $display("FAIL reset_outs: got %b expected 00000", {sel, wr_en, busy, err_timeout}); end
    n_cmp++; if ({start2, busy2} !== 5'd0) begin n_bad++; $display("FAIL reset_dut2: got %b expected 00000", {start2, busy2}); end
    req = 4'd0; rst_n = 1'b1;
    tick();
  endtask

  // Drain the scoreboard against the default-parameter instance.
  task automatic test_sequence(input string name, input logic [3:0] rq, input logic [3:0] dir);
    exp_t e;
    int cyc;
    req = rq; rd_wr = dir;
    tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_start(1'b0, cyc);
      n_cmp++; if (cyc !== e.gap) begin n_bad++; $display("FAIL %s_gap: got %0d idle cycles expected %0d", name, cyc, e.gap); end
      n_cmp++; if (start !== oh(e.grp)) begin n_bad++; $display("FAIL %s_start: got %b expected %b", name, start, oh(e.grp)); end
      n_cmp++; if ({sel, wr_en, busy} !== {e.grp, e.wr, 1'b1}) begin n_bad++; $display("FAIL %s_sel_wr_busy: got %b expected %b", name, {sel, wr_en, busy}, {e.grp, e.wr, 1'b1}); end
      repeat (e.hold) tick();
      n_cmp++; if ({start, busy} !== {oh(e.grp), 1'b1}) begin n_bad++; $display("FAIL %s_hold: got %b expected %b", name, {start, busy}, {oh(e.grp), 1'b1}); end
      if (sb_q.size() == 0) begin req = 4'd0; end
      done = oh(e.grp);
      tick();
      done = 4'd0;
      n_cmp++; if ({start, busy} !== 5'd0) begin n_bad++; $display("FAIL %s_release: got %b expected 00000", name, {start, busy}); end
    end
    repeat (5) tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    sb_q.push_back('{2'd0, 1'b0, 0, 2});
    sb_q.push_back('{2'd1, 1'b0, 1, 2});
    sb_q.push_back('{2'd2, 1'b0, 1, 2});
    sb_q.push_back('{2'd3, 1'b0, 1, 2});
    sb_q.push_back('{2'd0, 1'b0, 1, 2});
    test_sequence("rr", 4'hF, 4'h0);
  endtask

  task automatic test_same_group();
    do_reset();
    sb_q.push_back('{2'd0, 1'b0, 0, 1});
    sb_q.push_back('{2'd0, 1'b0, 3, 1});
    sb_q.push_back('{2'd0, 1'b0, 3, 1});
    test_sequence("same_grp", 4'b0001, 4'h0);
  endtask

  task automatic test_dir_switch();
    do_reset();
    sb_q.push_back('{2'd0, 1'b0, 0, 2});
    sb_q.push_back('{2'd1, 1'b1, 3, 2});
    test_sequence("dir_sw", 4'b0011, 4'b0010);
  endtask

  task automatic test_timeout();
    int cyc;
    int cnt;
    exp_t e;
    do_reset();
    req = 4'b0100; rd_wr = 4'h0;
    tick();
    wait_start(1'b0, cyc);
    n_cmp++; if (start !== 4'b0100) begin n_bad++; $display("FAIL to_grant_c: got %b expected 0100", start); end
    req = 4'b1000;
    sb_q.push_back('{2'd3, 1'b0, 1, 2});
    cnt = 1;
    while ((busy === 1'b1) && (cnt < 100)) begin
      n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_early_err: got %b expected 0 at active cycle %0d", err_timeout, cnt); end
      tick();
      if (busy === 1'b1) begin cnt++; end
    end
    n_cmp++; if (cnt !== 64) begin n_bad++; $display("FAIL to_length: got %0d active cycles expected 64", cnt); end
    n_cmp++; if ({err_timeout, busy, start} !== 6'b100000) begin n_bad++; $display("FAIL to_pulse: got %b expected 100000", {err_timeout, busy, start}); end
    e = sb_q.pop_front();
    wait_start(1'b0, cyc);
    n_cmp++; if (cyc !== e.gap) begin n_bad++; $display("FAIL to_next_gap: got %0d expected %0d", cyc, e.gap); end
    n_cmp++; if ({start, sel, err_timeout} !== {oh(e.grp), e.grp, 1'b0}) begin n_bad++; $display("FAIL to_next_grant: got %b expected %b", {start, sel, err_timeout}, {oh(e.grp), e.grp, 1'b0}); end
    req = 4'd0;
    done = 4'b0100;
    tick();
    done = 4'd0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_foreign_done: got busy %b expected 1", busy); end
    done = 4'b1000;
    tick();
    done = 4'd0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    int zeros;
    do_reset();
    sb_q.push_back('{2'd1, 1'b0, 0, 2});
    sb_q.push_back('{2'd2, 1'b0, 0, 2});
    sb_q.push_back('{2'd1, 1'b0, 0, 2});
    req2 = 4'b0110; rd_wr2 = 4'h0;
    tick();
    zeros = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_start(1'b1, cyc);
      n_cmp++; if (cyc !== e.gap) begin n_bad++; $display("FAIL b2b_gap: got %0d expected %0d", cyc, e.gap); end
      n_cmp++; if ({start2, sel2, busy2} !== {oh(e.grp), e.grp, 1'b1}) begin n_bad++; $display("FAIL b2b_grant: got %b expected %b", {start2, sel2, busy2}, {oh(e.grp), e.grp, 1'b1}); end
      for (int i = 0; i < e.hold; i++) begin
        tick();
        if (start2 == 4'd0) begin zeros++; end
      end
      if (sb_q.size() == 0) begin req2 = 4'd0; end
      done2 = oh(e.grp);
      tick();
      done2 = 4'd0;
    end
    n_cmp++; if (zeros !== 0) begin n_bad++; $display("FAIL b2b_no_bubble: got %0d zero cycles expected 0", zeros); end
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL b2b_final_idle: got %b expected 0", busy2); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000; rd_wr = 4'b1000;
    tick();
    n_cmp++; if ({start, wr_en} !== 5'b10001) begin n_bad++; $display("FAIL rm_grant_d: got %b expected 10001", {start, wr_en}); end
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({start, sel, wr_en, busy, err_timeout} !== 9'd0) begin n_bad++; $display("FAIL rm_abort: got %b expected 000000000", {start, sel, wr_en, busy, err_timeout}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({start, sel, busy} !== 7'b1000111) begin n_bad++; $display("FAIL rm_regrant: got %b expected 1000111", {start, sel, busy}); end
    req = 4'd0;
    done = 4'b1000;
    tick();
    done = 4'd0;
    repeat (4) tick();
    req = 4'b1001; rd_wr = 4'h0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (start !== 4'b0001) begin n_bad++; $display("FAIL rm_first_from_a: got %b expected 0001", start); end
    req = 4'd0;
    done = 4'b0001;
    tick();
    done = 4'd0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; rd_wr = 4'd0; done = 4'd0;
    req2 = 4'd0; rd_wr2 = 4'd0; done2 = 4'd0;
    test_reset();
    test_round_robin();
    test_same_group();
    test_dir_switch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
